axi4_read_crossbar: RTL and testbench

//  NUM_MASTERS x NUM_SLAVES AXI4 read-path crossbar (AR + R channels) for bench and RTL-top use.

---
 rtl/axi4_read_crossbar.sv | 274 +++++++++++++++++++++++++++
 tb/tb_axi4_read_crossbar.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_read_crossbar.sv
// AXI4 read-path crossbar: address decode, per-target round-robin arbitration,
// R bursts routed back to the granting master, DECERR default slave for holes.

module axi4_rd_xbar_tgt #(
  parameter int NM = 4,
  parameter int MW = 2
) (
  input  logic          aclk,
  input  logic          aresetn,
  input  logic [NM-1:0] req,
  input  logic          ar_hs,
  input  logic          r_done,
  output logic          st_addr,
  output logic          st_data,
  output logic [MW-1:0] gnt,
  output logic [NM-1:0] pick
);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} st_e;
  st_e st_q, st_d;
  logic [MW-1:0] gnt_d, ptr_q, ptr_d;
  int j;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      st_q  <= IDLE;
      gnt   <= '0;
      ptr_q <= '0;
    end else begin
      st_q  <= st_d;
      gnt   <= gnt_d;
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    st_d  = st_q;
    gnt_d = gnt;
    ptr_d = ptr_q;
    pick  = '0;
    j     = 0;
    case (st_q)
      IDLE: begin
        // first requester at or after the round-robin pointer
        for (int i = 0; i < NM; i++) begin
          j = (int'(ptr_q) + i) % NM;
          if (pick == '0 && req[j]) begin
            pick[j] = 1'b1;
            gnt_d   = MW'(j);
          end
        end
        if (pick != '0) st_d = ADDR;
      end
      ADDR: if (ar_hs) st_d = DATA;
      DATA: begin
        if (r_done) begin
          st_d  = IDLE;
          ptr_d = (int'(gnt) == NM-1) ? '0 : gnt + 1'b1;
        end
      end
      default: st_d = IDLE;
    endcase
  end

  assign st_addr = (st_q == ADDR);
  assign st_data = (st_q == DATA);
endmodule

module axi4_read_crossbar #(
  parameter int NUM_MASTERS = 4,
  parameter int NUM_SLAVES  = 4,
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 256,
  parameter int ID_WIDTH    = 4,
  parameter int REGION_LOG2 = 28,
  parameter logic [NUM_SLAVES-1:0][ADDR_WIDTH-1:0] SLAVE_BASE =
    {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}
) (
  input  logic                            aclk,
  input  logic                            aresetn,
  input  logic [NUM_MASTERS*ID_WIDTH-1:0]   m_arid,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [NUM_MASTERS*8-1:0]          m_arlen,
  input  logic [NUM_MASTERS*3-1:0]          m_arsize,
  input  logic [NUM_MASTERS*2-1:0]          m_arburst,
  input  logic [NUM_MASTERS-1:0]            m_arvalid,
  output logic [NUM_MASTERS-1:0]            m_arready,
  output logic [NUM_MASTERS*ID_WIDTH-1:0]   m_rid,
  output logic [NUM_MASTERS*DATA_WIDTH-1:0] m_rdata,
  output logic [NUM_MASTERS*2-1:0]          m_rresp,
  output logic [NUM_MASTERS-1:0]            m_rlast,
  output logic [NUM_MASTERS-1:0]            m_rvalid,
  input  logic [NUM_MASTERS-1:0]            m_rready,
  output logic [NUM_SLAVES*ID_WIDTH-1:0]    s_arid,
  output logic [NUM_SLAVES*ADDR_WIDTH-1:0]  s_araddr,
  output logic [NUM_SLAVES*8-1:0]           s_arlen,
  output logic [NUM_SLAVES*3-1:0]           s_arsize,
  output logic [NUM_SLAVES*2-1:0]           s_arburst,
  output logic [NUM_SLAVES-1:0]             s_arvalid,
  input  logic [NUM_SLAVES-1:0]             s_arready,
  input  logic [NUM_SLAVES*ID_WIDTH-1:0]    s_rid,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0]  s_rdata,
  input  logic [NUM_SLAVES*2-1:0]           s_rresp,
  input  logic [NUM_SLAVES-1:0]             s_rlast,
  input  logic [NUM_SLAVES-1:0]             s_rvalid,
  output logic [NUM_SLAVES-1:0]             s_rready
);
  localparam int NM = NUM_MASTERS;
  localparam int NS = NUM_SLAVES;
  localparam int NT = NS + 1;
  localparam int AW = ADDR_WIDTH;
  localparam int DW = DATA_WIDTH;
  localparam int IW = ID_WIDTH;
  localparam int TW = $clog2(NT);
  localparam int MW = (NM > 1) ? $clog2(NM) : 1;

  logic [NM-1:0][IW-1:0] ma_id, mr_id;
  logic [NM-1:0][AW-1:0] ma_addr;
  logic [NM-1:0][7:0]    ma_len;
  logic [NM-1:0][2:0]    ma_size;
  logic [NM-1:0][1:0]    ma_burst, mr_resp;
  logic [NM-1:0][DW-1:0] mr_data;
  logic [NM-1:0]         ma_ready, mr_last, mr_valid;

  assign ma_id    = m_arid;
  assign ma_addr  = m_araddr;
  assign ma_len   = m_arlen;
  assign ma_size  = m_arsize;
  assign ma_burst = m_arburst;
  assign m_arready = ma_ready;
  assign m_rid    = mr_id;
  assign m_rdata  = mr_data;
  assign m_rresp  = mr_resp;
  assign m_rlast  = mr_last;
  assign m_rvalid = mr_valid;

  // targets 0..NS-1 are the slave ports, target NS is the internal default slave
  logic [NT-1:0]         t_addr, t_data, t_arready, t_rvalid, t_rready, t_rlast;
  logic [NT-1:0][MW-1:0] t_gnt;
  logic [NT-1:0][NM-1:0] t_req, t_pick;
  logic [NT-1:0][IW-1:0] t_arid, t_rid;
  logic [NT-1:0][7:0]    t_arlen;
  logic [NT-1:0][1:0]    t_rresp;
  logic [NT-1:0][DW-1:0] t_rdata;
  logic [NS-1:0][AW-1:0] sa_addr;
  logic [NS-1:0][2:0]    sa_size;
  logic [NS-1:0][1:0]    sa_burst;
  logic [NM-1:0][TW-1:0] m_tgt;
  logic [NM-1:0]         busy_q, busy_set, busy_clr;
  logic [IW-1:0]         d_id;
  logic [7:0]            d_len, d_cnt;

  assign t_arready = {1'b1, s_arready};
  assign t_rvalid  = {t_data[NS], s_rvalid};
  assign t_rlast   = {(d_cnt == d_len), s_rlast};
  assign t_rid     = {d_id, s_rid};
  assign t_rresp   = {2'b11, s_rresp};
  assign t_rdata   = {{DW{1'b0}}, s_rdata};

  assign s_arid    = t_arid[NS-1:0];
  assign s_arlen   = t_arlen[NS-1:0];
  assign s_araddr  = sa_addr;
  assign s_arsize  = sa_size;
  assign s_arburst = sa_burst;
  assign s_arvalid = t_addr[NS-1:0];
  assign s_rready  = t_rready[NS-1:0];

  // reverse scan so the lowest matching slave index wins on overlap
  always_comb begin
    m_tgt = '0;
    for (int m = 0; m < NM; m++) begin
      m_tgt[m] = TW'(NS);
      for (int s = NS-1; s >= 0; s--)
        if (ma_addr[m][AW-1:REGION_LOG2] == SLAVE_BASE[s][AW-1:REGION_LOG2])
          m_tgt[m] = TW'(s);
    end
  end

  always_comb begin
    t_req = '0;
    for (int t = 0; t < NT; t++)
      for (int m = 0; m < NM; m++)
        t_req[t][m] = m_arvalid[m] && !busy_q[m] && (m_tgt[m] == TW'(t));
  end

  for (genvar t = 0; t < NT; t++) begin : g_tgt
    axi4_rd_xbar_tgt #(.NM(NM), .MW(MW)) u_tgt (
      .aclk    (aclk),
      .aresetn (aresetn),
      .req     (t_req[t]),
      .ar_hs   (t_addr[t] & t_arready[t]),
      .r_done  (t_data[t] & t_rvalid[t] & t_rready[t] & t_rlast[t]),
      .st_addr (t_addr[t]),
      .st_data (t_data[t]),
      .gnt     (t_gnt[t]),
      .pick    (t_pick[t])
    );
  end

  always_comb begin
    t_arid   = '0;
    t_arlen  = '0;
    sa_addr  = '0;
    sa_size  = '0;
    sa_burst = '0;
    for (int t = 0; t < NT; t++)
      if (t_addr[t]) begin
        t_arid[t]  = ma_id[t_gnt[t]];
        t_arlen[t] = ma_len[t_gnt[t]];
      end
    for (int s = 0; s < NS; s++)
      if (t_addr[s]) begin
        sa_addr[s]  = ma_addr[t_gnt[s]];
        sa_size[s]  = ma_size[t_gnt[s]];
        sa_burst[s] = ma_burst[t_gnt[s]];
      end
  end

  always_comb begin
    t_rready = '0;
    for (int t = 0; t < NT; t++)
      t_rready[t] = t_data[t] && m_rready[t_gnt[t]];
  end

  always_comb begin
    ma_ready = '0;
    mr_id    = '0;
    mr_data  = '0;
    mr_resp  = '0;
    mr_last  = '0;
    mr_valid = '0;
    for (int t = 0; t < NT; t++)
      for (int m = 0; m < NM; m++)
        if (t_gnt[t] == MW'(m)) begin
          if (t_addr[t] && t_arready[t]) ma_ready[m] = 1'b1;
          if (t_data[t]) begin
            mr_valid[m] = t_rvalid[t];
            mr_id[m]    = t_rid[t];
            mr_data[m]  = t_rdata[t];
            mr_resp[m]  = t_rresp[t];
            mr_last[m]  = t_rlast[t];
          end
        end
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    for (int t = 0; t < NT; t++) begin
      busy_set = busy_set | t_pick[t];
      if (t_data[t] && t_rvalid[t] && t_rready[t] && t_rlast[t])
        busy_clr[t_gnt[t]] = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) busy_q <= '0;
    else          busy_q <= (busy_q & ~busy_clr) | busy_set;
  end

  // default slave: ADDR lasts one cycle (arready tied high), so capture there
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      d_id  <= '0;
      d_len <= '0;
      d_cnt <= '0;
    end else if (t_addr[NS]) begin
      d_id  <= t_arid[NS];
      d_len <= t_arlen[NS];
      d_cnt <= '0;
    end else if (t_data[NS] && t_rready[NS]) begin
      d_cnt <= d_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_axi4_read_crossbar.sv
// Directed bench for axi4_read_crossbar: stimulus pushes expected R beats into
// per-master queues, a negedge monitor pops and compares every accepted beat.

module tb_axi4_read_crossbar;
  localparam int NM = 4;
  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 256;
  localparam int IW = 4;

  typedef struct packed {
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;

  logic [NM-1:0][IW-1:0] m_arid, m_rid;
  logic [NM-1:0][AW-1:0] m_araddr;
  logic [NM-1:0][7:0]    m_arlen;
  logic [NM-1:0][2:0]    m_arsize;
  logic [NM-1:0][1:0]    m_arburst, m_rresp;
  logic [NM-1:0][DW-1:0] m_rdata;
  logic [NM-1:0]         m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

  logic [NS-1:0][IW-1:0] s_arid, s_rid;
  logic [NS-1:0][AW-1:0] s_araddr;
  logic [NS-1:0][7:0]    s_arlen;
  logic [NS-1:0][2:0]    s_arsize;
  logic [NS-1:0][1:0]    s_arburst, s_rresp;
  logic [NS-1:0][DW-1:0] s_rdata;
  logic [NS-1:0]         s_arvalid, s_arready, s_rlast, s_rvalid, s_rready;

  int pass_cnt = 0;
  int chk_cnt = 0;
  beat_t exp_q[NM][$];

  axi4_read_crossbar dut (
    .aclk(aclk), .aresetn(aresetn),
    .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .s_arid(s_arid), .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rid(s_rid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .s_rvalid(s_rvalid), .s_rready(s_rready)
  );

  initial forever #5 aclk = ~aclk;

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a, input logic [7:0] b);
    return {160'h0, 32'hC0DE_0000, a, 24'h0, b};
  endfunction

  function automatic logic outs_any();
    return |{m_arready, m_rid, m_rdata, m_rresp, m_rlast, m_rvalid, s_arid, s_araddr,
             s_arlen, s_arsize, s_arburst, s_arvalid, s_rready};
  endfunction

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic fail(input string name);
    chk_cnt++;
    $display("FAIL %s: got timeout expected event within bound", name);
  endtask

  // queue the expected beats, then hold AR until accepted
  task automatic issue(input int m, input logic [IW-1:0] id, input logic [AW-1:0] a,
                       input logic [7:0] len);
    beat_t b;
    bit unmapped;
    bit ok;
    unmapped = (a[31:28] > 4'h3);
    ok = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      b.id   = id;
      b.resp = unmapped ? 2'b11 : 2'b00;
      b.last = (i == int'(len));
      b.data = unmapped ? '0 : pat(a, 8'(i));
      exp_q[m].push_back(b);
    end
    m_arid[m] = id; m_araddr[m] = a; m_arlen[m] = len;
    m_arsize[m] = 3'd5; m_arburst[m] = 2'b01; m_arvalid[m] = 1'b1;
    for (int k = 0; k < 64 && !ok; k++) begin
      @(negedge aclk);
      if (m_arready[m]) ok = 1'b1;
    end
    @(posedge aclk); #1;
    m_arvalid[m] = 1'b0;
    if (!ok) fail($sformatf("ar_accept_m%0d", m));
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(posedge aclk); #1;
      done = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) &&
             (exp_q[2].size() == 0) && (exp_q[3].size() == 0);
    end
    if (!done) fail("drain");
    repeat (2) begin @(posedge aclk); #1; end
  endtask

  // scoreboard monitor
  always @(negedge aclk) begin
    beat_t e;
    if (aresetn) begin
      for (int m = 0; m < NM; m++) begin
        if (m_rvalid[m] && m_rready[m]) begin
          if (exp_q[m].size() == 0) begin
            fail($sformatf("unexpected_beat_m%0d", m));
          end else begin
            e = exp_q[m].pop_front();
            chk($sformatf("beat_m%0d", m),
                {57'b0, m_rid[m], m_rresp[m], m_rlast[m], m_rdata[m]}, {57'b0, e});
          end
        end
      end
    end
  end

  // slave models: always ready for AR, stream arlen+1 beats honouring s_rready
  initial begin
    logic [NS-1:0][IW-1:0] sl_id;
    logic [NS-1:0][AW-1:0] sl_addr;
    logic [NS-1:0][7:0]    sl_len, sl_beat;
    logic [NS-1:0]         sl_act, arhs, rhs;
    sl_id = '0; sl_addr = '0; sl_len = '0; sl_beat = '0; sl_act = '0;
    s_arready = '1; s_rvalid = '0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = '0;
    forever begin
      @(negedge aclk);
      for (int s = 0; s < NS; s++) begin
        arhs[s] = s_arvalid[s] && s_arready[s];
        rhs[s]  = s_rvalid[s] && s_rready[s];
        if (arhs[s]) begin
          sl_id[s] = s_arid[s]; sl_addr[s] = s_araddr[s]; sl_len[s] = s_arlen[s];
        end
      end
      @(posedge aclk); #1;
      for (int s = 0; s < NS; s++) begin
        if (!aresetn) begin
          sl_act[s] = 1'b0;
        end else begin
          if (rhs[s]) begin
            if (sl_beat[s] == sl_len[s]) sl_act[s] = 1'b0;
            else sl_beat[s] = sl_beat[s] + 8'd1;
          end
          if (arhs[s]) begin
            sl_act[s] = 1'b1;
            sl_beat[s] = 8'd0;
          end
        end
        s_rvalid[s] = sl_act[s];
        s_rid[s]    = sl_act[s] ? sl_id[s] : '0;
        s_rdata[s]  = sl_act[s] ? pat(sl_addr[s], sl_beat[s]) : '0;
        s_rresp[s]  = 2'b00;
        s_rlast[s]  = sl_act[s] && (sl_beat[s] == sl_len[s]);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, flag;
    m_arid = '0; m_araddr = '0; m_arlen = '0; m_arsize = '0; m_arburst = '0;
    m_arvalid = '0; m_rready = '1;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset_outputs", outs_any(), 0);
    aresetn = 1'b1;
    @(posedge aclk); #1;

    // 1: single burst to S0, one registered arbitration cycle
    fork
      issue(0, 4'h5, 32'h0000_1000, 8'd3);
      begin
        @(negedge aclk);
        chk("t1_arvalid_c0", s_arvalid, 0);
        @(negedge aclk);
        chk("t1_arvalid_c1", s_arvalid, 4'b0001);
        chk("t1_araddr", s_araddr[0], 32'h0000_1000);
        chk("t1_arlen", s_arlen[0], 8'd3);
      end
    join
    flag = 1'b0;
    for (int k = 0; k < 40 && exp_q[0].size() != 0; k++) begin
      @(negedge aclk);
      flag = flag | (|m_rvalid[3:1]);
    end
    chk("t1_others_quiet", flag, 0);
    wait_idle();

    // 2: contention on S1, then rotation after M0 re-requests right after rlast
    fork
      issue(0, 4'h1, 32'h1000_0000, 8'd1);
      issue(1, 4'h2, 32'h1000_0040, 8'd1);
      begin
        @(negedge aclk); @(negedge aclk);
        chk("t2_first_m0", {s_arvalid[1], s_arid[1]}, {1'b1, 4'h1});
        found = 1'b0;
        for (int k = 0; k < 50 && !found; k++) begin
          @(negedge aclk);
          if (m_rvalid[0] && m_rready[0] && m_rlast[0]) found = 1'b1;
        end
        if (!found) fail("t2_m0_rlast");
        @(posedge aclk); #1;
        fork
          issue(0, 4'h3, 32'h1000_0080, 8'd0);
          begin
            @(negedge aclk);
            chk("t2_idle_gap", s_arvalid[1], 0);
            @(negedge aclk);
            chk("t2_rr_m1", {s_arvalid[1], s_arid[1]}, {1'b1, 4'h2});
          end
        join
      end
    join
    wait_idle();

    // 3: unmapped address answered by the default slave
    fork
      issue(2, 4'h7, 32'hF000_0000, 8'd1);
      begin
        flag = 1'b0;
        repeat (10) begin
          @(negedge aclk);
          flag = flag | (|s_arvalid);
        end
        chk("t3_no_slave_ar", flag, 0);
      end
    join
    wait_idle();

    // 4: two masters to two slaves in parallel
    fork
      issue(0, 4'h8, 32'h0000_2000, 8'd3);
      issue(1, 4'h9, 32'h1000_0100, 8'd3);
      begin
        @(negedge aclk); @(negedge aclk);
        chk("t4_both_ar", s_arvalid, 4'b0011);
        flag = 1'b0;
        repeat (8) begin
          @(negedge aclk);
          flag = flag | (m_rvalid[0] && m_rvalid[1]);
        end
        chk("t4_overlap", flag, 1);
      end
    join
    wait_idle();

    // 5: master backpressure mid-burst holds the beat
    fork
      issue(0, 4'hA, 32'h0000_3000, 8'd3);
      begin
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
          @(negedge aclk);
          if (m_rvalid[0] && m_rready[0]) found = 1'b1;
        end
        if (!found) fail("t5_first_beat");
        @(posedge aclk); #1;
        m_rready[0] = 1'b0;
        repeat (3) begin
          @(negedge aclk);
          chk("t5_hold", {s_rready[0], m_rvalid[0], m_rdata[0]},
              {1'b0, 1'b1, pat(32'h0000_3000, 8'd1)});
        end
        @(posedge aclk); #1;
        m_rready[0] = 1'b1;
      end
    join
    wait_idle();

    // 6: asynchronous reset during beat 2, then a fresh read
    fork
      issue(0, 4'hB, 32'h0000_4000, 8'd3);
      begin
        found = 1'b0;
        for (int k = 0; k < 30 && !found; k++) begin
          @(negedge aclk);
          if (m_rvalid[0] && m_rready[0]) found = 1'b1;
        end
        if (!found) fail("t6_first_beat");
        @(negedge aclk);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_async_zero", outs_any(), 0);
      end
    join
    exp_q[0].delete();
    repeat (2) begin @(posedge aclk); #1; end
    aresetn = 1'b1;
    @(posedge aclk); #1;
    chk("t6_post_reset_idle", outs_any(), 0);
    issue(0, 4'hC, 32'h0000_5000, 8'd3);
    wait_idle();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
